// File: rtl/l2_msg_ingress_sched.sv
// l2_msg_ingress_sched
// Ingress scheduler in front of the L2 single-line pipeline. Arbitrates new
// core requests (msg1) against forward acks/responses (msg3) and hands one
// message at a time to the pipeline through a one-entry output register.
// While a forward issued by the pipeline awaits its FWDACK, new requests are
// blocked and only the matching ack may enter.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   msg1_valid/ready, msg1_*      core request channel (ready is combinational)
//   msg3_valid/ready, msg3_*      response/ack channel (ready is combinational)
//   pipe_valid/ready, pipe_sel,   held message towards the pipeline
//   pipe_*                        (pipe_sel: 0 = msg1, 1 = msg3)
//   fwd_req, fwd_tag              pipeline pulse: forward sent for fwd_tag
//   cur_state                     0 IDLE, 1 WAIT_ACK, 2 DONE
//   timeout_err, proto_err        sticky error flags, cleared by rst only
module l2_msg_ingress_sched #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned TAG_W      = 26,
  parameter int unsigned SRC_W      = 6,
  parameter int unsigned TYPE_W     = 8,
  parameter int unsigned ACK_LO     = 'h15,
  parameter int unsigned ACK_HI     = 'h17,
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned FWD_TMO    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg1_valid,
  output logic              msg1_ready,
  input  logic [TYPE_W-1:0] msg1_type,
  input  logic [SRC_W-1:0]  msg1_source,
  input  logic [TAG_W-1:0]  msg1_tag,
  input  logic [DATA_W-1:0] msg1_data,
  input  logic              msg3_valid,
  output logic              msg3_ready,
  input  logic [TYPE_W-1:0] msg3_type,
  input  logic [SRC_W-1:0]  msg3_source,
  input  logic [TAG_W-1:0]  msg3_tag,
  input  logic [DATA_W-1:0] msg3_data,
  output logic              pipe_valid,
  input  logic              pipe_ready,
  output logic              pipe_sel,
  output logic [TYPE_W-1:0] pipe_type,
  output logic [SRC_W-1:0]  pipe_source,
  output logic [TAG_W-1:0]  pipe_tag,
  output logic [DATA_W-1:0] pipe_data,
  input  logic              fwd_req,
  input  logic [TAG_W-1:0]  fwd_tag,
  output logic [1:0]        cur_state,
  output logic              timeout_err,
  output logic              proto_err
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned TMO_W    = $clog2(FWD_TMO + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STARVE_W-1:0] starve_q;
  logic [TMO_W-1:0]    tmo_q;
  logic [TAG_W-1:0]    wait_tag_q;

  logic slot_free;
  logic is_ack;
  logic starved;
  logic tmo_hit;
  logic msg1_win;

  assign slot_free = !pipe_valid || pipe_ready;
  assign is_ack    = (msg3_type >= TYPE_W'(ACK_LO)) && (msg3_type <= TYPE_W'(ACK_HI));
  assign starved   = (starve_q == STARVE_W'(STARVE_MAX));
  assign tmo_hit   = (tmo_q == TMO_W'(FWD_TMO));
  assign cur_state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and combinational grants
  always_comb begin
    state_d    = state_q;
    msg1_ready = 1'b0;
    msg3_ready = 1'b0;
    msg1_win   = 1'b0;
    case (state_q)
      IDLE: begin
        // msg3 has priority unless msg1 has lost STARVE_MAX times in a row;
        // a forward launched this cycle closes the door on msg1 at once.
        msg1_win = msg1_valid && !fwd_req && (!msg3_valid || starved);
        if (!rst && slot_free) begin
          msg1_ready = msg1_win;
          msg3_ready = msg3_valid && !msg1_win;
        end
        if (fwd_req) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!rst && slot_free && msg3_valid && is_ack && (msg3_tag == wait_tag_q))
          msg3_ready = 1'b1;
        if (msg3_ready)   state_d = DONE;
        else if (tmo_hit) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation/timeout counters, forward tag and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      tmo_q       <= '0;
      wait_tag_q  <= '0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (msg1_ready)
          starve_q <= '0;
        else if (msg1_valid && slot_free && msg3_ready && !starved)
          starve_q <= starve_q + STARVE_W'(1);
        if (fwd_req) begin
          wait_tag_q <= fwd_tag;
          tmo_q      <= '0;
        end
      end
      if (state_q == WAIT_ACK) begin
        if (!tmo_hit) tmo_q <= tmo_q + TMO_W'(1);
        if (!msg3_ready && tmo_hit) timeout_err <= 1'b1;
      end
      if (fwd_req && (state_q != IDLE)) proto_err <= 1'b1;
    end
  end

  // One-entry output register; holds while the pipeline stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid  <= 1'b0;
      pipe_sel    <= 1'b0;
      pipe_type   <= '0;
      pipe_source <= '0;
      pipe_tag    <= '0;
      pipe_data   <= '0;
    end else if (msg1_ready) begin
      pipe_valid  <= 1'b1;
      pipe_sel    <= 1'b0;
      pipe_type   <= msg1_type;
      pipe_source <= msg1_source;
      pipe_tag    <= msg1_tag;
      pipe_data   <= msg1_data;
    end else if (msg3_ready) begin
      pipe_valid  <= 1'b1;
      pipe_sel    <= 1'b1;
      pipe_type   <= msg3_type;
      pipe_source <= msg3_source;
      pipe_tag    <= msg3_tag;
      pipe_data   <= msg3_data;
    end else if (pipe_ready) begin
      pipe_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_msg_ingress_sched.sv
// Directed bench for l2_msg_ingress_sched. Expected pipeline payloads are
// queued when a grant is expected and compared when the pipeline consumes.
module tb_l2_msg_ingress_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg1_valid, msg1_ready;
  logic [7:0]  msg1_type;
  logic [5:0]  msg1_source;
  logic [25:0] msg1_tag;
  logic [63:0] msg1_data;
  logic        msg3_valid, msg3_ready;
  logic [7:0]  msg3_type;
  logic [5:0]  msg3_source;
  logic [25:0] msg3_tag;
  logic [63:0] msg3_data;
  logic        pipe_valid, pipe_ready, pipe_sel;
  logic [7:0]  pipe_type;
  logic [5:0]  pipe_source;
  logic [25:0] pipe_tag;
  logic [63:0] pipe_data;
  logic        fwd_req;
  logic [25:0] fwd_tag;
  logic [1:0]  cur_state;
  logic        timeout_err, proto_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] sb[$];

  l2_msg_ingress_sched dut (
    .clk(clk), .rst(rst),
    .msg1_valid(msg1_valid), .msg1_ready(msg1_ready), .msg1_type(msg1_type),
    .msg1_source(msg1_source), .msg1_tag(msg1_tag), .msg1_data(msg1_data),
    .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
    .msg3_source(msg3_source), .msg3_tag(msg3_tag), .msg3_data(msg3_data),
    .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_sel(pipe_sel),
    .pipe_type(pipe_type), .pipe_source(pipe_source), .pipe_tag(pipe_tag),
    .pipe_data(pipe_data), .fwd_req(fwd_req), .fwd_tag(fwd_tag),
    .cur_state(cur_state), .timeout_err(timeout_err), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] pk(input logic sel, input logic [7:0] ty,
                                      input logic [5:0] src, input logic [25:0] tg,
                                      input logic [63:0] d);
    return 128'({sel, ty, src, tg, d});
  endfunction

  // Inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set1(input logic v, input logic [7:0] ty, input logic [25:0] tg);
    msg1_valid = v; msg1_type = ty; msg1_source = 6'h03; msg1_tag = tg;
    msg1_data = {38'h1, tg};
  endtask

  task automatic set3(input logic v, input logic [7:0] ty, input logic [25:0] tg);
    msg3_valid = v; msg3_type = ty; msg3_source = 6'h2A; msg3_tag = tg;
    msg3_data = {38'h3, tg};
  endtask

  function automatic logic [127:0] exp1(input logic [7:0] ty, input logic [25:0] tg);
    return pk(1'b0, ty, 6'h03, tg, {38'h1, tg});
  endfunction

  function automatic logic [127:0] exp3(input logic [7:0] ty, input logic [25:0] tg);
    return pk(1'b1, ty, 6'h2A, tg, {38'h3, tg});
  endfunction

  // Scoreboard: compare each message as the pipeline consumes it
  always @(negedge clk) begin
    if (rst === 1'b0 && pipe_valid === 1'b1 && pipe_ready === 1'b1) begin
      chk("sb_has_entry", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0)
        chk("pipe_payload", pk(pipe_sel, pipe_type, pipe_source, pipe_tag, pipe_data),
            sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad_rdy;

    rst = 1'b1; pipe_ready = 1'b0; fwd_req = 1'b0; fwd_tag = '0;
    set1(1'b1, 8'h01, 26'h0); set3(1'b1, 8'h20, 26'h0);
    tick(); tick(); settle();
    chk("rst_msg1_ready", 128'(msg1_ready), 128'(0));
    chk("rst_msg3_ready", 128'(msg3_ready), 128'(0));
    chk("rst_pipe_valid", 128'(pipe_valid), 128'(0));
    chk("rst_pipe_fields", pk(pipe_sel, pipe_type, pipe_source, pipe_tag, pipe_data), 128'(0));
    chk("rst_state", 128'(cur_state), 128'(0));
    chk("rst_errs", 128'({timeout_err, proto_err}), 128'(0));
    tick();
    rst = 1'b0; set1(1'b0, 8'h0, 26'h0); set3(1'b0, 8'h0, 26'h0);
    pipe_ready = 1'b1;
    tick();

    // 1: single msg1, 1-cycle latency
    set1(1'b1, 8'h01, 26'h0AB); settle();
    chk("t1_msg1_ready", 128'(msg1_ready), 128'(1));
    chk("t1_msg3_ready", 128'(msg3_ready), 128'(0));
    sb.push_back(exp1(8'h01, 26'h0AB));
    tick(); set1(1'b0, 8'h0, 26'h0); settle();
    chk("t1_pipe_valid", 128'(pipe_valid), 128'(1));
    chk("t1_pipe_sel", 128'(pipe_sel), 128'(0));
    chk("t1_pipe_tag", 128'(pipe_tag), 128'(26'h0AB));
    tick(); settle();
    chk("t1_drained", 128'(pipe_valid), 128'(0));

    // 2: starvation: msg3 wins 15 grants, msg1 the 16th, then msg3 again
    for (int g = 0; g < 17; g++) begin
      set1(1'b1, 8'h02, 26'(32'h100 + g));
      set3(1'b1, 8'h20, 26'(g));
      settle();
      if (g == 15) begin
        chk($sformatf("t2_g%0d_msg1", g), 128'(msg1_ready), 128'(1));
        chk($sformatf("t2_g%0d_msg3", g), 128'(msg3_ready), 128'(0));
        sb.push_back(exp1(8'h02, 26'(32'h100 + g)));
      end else begin
        chk($sformatf("t2_g%0d_msg1", g), 128'(msg1_ready), 128'(0));
        chk($sformatf("t2_g%0d_msg3", g), 128'(msg3_ready), 128'(1));
        sb.push_back(exp3(8'h20, 26'(g)));
      end
      tick();
    end
    set1(1'b0, 8'h0, 26'h0); set3(1'b0, 8'h0, 26'h0);
    tick();

    // 3: forward wait; wrong-tag ack held, matching ack accepted
    fwd_req = 1'b1; fwd_tag = 26'h0AB; set1(1'b1, 8'h03, 26'h200); settle();
    chk("t3_fwd_msg1_blocked", 128'(msg1_ready), 128'(0));
    tick(); fwd_req = 1'b0;
    set3(1'b1, 8'h15, 26'h0CD); settle();
    chk("t3_state_wait", 128'(cur_state), 128'(1));
    chk("t3_wrongtag_held", 128'({msg1_ready, msg3_ready}), 128'(0));
    tick();
    set3(1'b1, 8'h15, 26'h0AB); settle();
    chk("t3_ack_ready", 128'({msg1_ready, msg3_ready}), 128'(1));
    sb.push_back(exp3(8'h15, 26'h0AB));
    tick(); set3(1'b0, 8'h0, 26'h0); settle();
    chk("t3_state_done", 128'(cur_state), 128'(2));
    chk("t3_done_msg1_blocked", 128'(msg1_ready), 128'(0));
    tick(); settle();
    chk("t3_state_idle", 128'(cur_state), 128'(0));
    chk("t3_msg1_after_idle", 128'(msg1_ready), 128'(1));
    sb.push_back(exp1(8'h03, 26'h200));
    tick(); set1(1'b0, 8'h0, 26'h0);
    tick();

    // 4: pipeline stall holds the register; drain and refill on one edge
    pipe_ready = 1'b0; set1(1'b1, 8'h04, 26'h300); settle();
    chk("t4_load", 128'(msg1_ready), 128'(1));
    sb.push_back(exp1(8'h04, 26'h300));
    tick();
    set1(1'b1, 8'h05, 26'h301); set3(1'b1, 8'h21, 26'h0EE);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t4_stall%0d_readies", c), 128'({msg1_ready, msg3_ready}), 128'(0));
      chk($sformatf("t4_stall%0d_pipe", c),
          pk(pipe_valid, pipe_type, pipe_source, pipe_tag, 64'(pipe_sel)),
          pk(1'b1, 8'h04, 6'h03, 26'h300, 64'h0));
      tick();
    end
    pipe_ready = 1'b1; settle();
    chk("t4_refill_grant", 128'({msg1_ready, msg3_ready}), 128'(1));
    sb.push_back(exp3(8'h21, 26'h0EE));
    tick(); set1(1'b0, 8'h0, 26'h0); set3(1'b0, 8'h0, 26'h0); settle();
    chk("t4_refilled", 128'({pipe_valid, pipe_sel, pipe_tag}), 128'({2'b11, 26'h0EE}));
    tick();

    // 5: forward with no ack times out
    fwd_req = 1'b1; fwd_tag = 26'h111;
    tick(); fwd_req = 1'b0; set1(1'b1, 8'h06, 26'h400);
    n = 0; bad_rdy = 1'b0;
    while (cur_state == 2'd1 && n < 400) begin
      settle();
      if (msg1_ready !== 1'b0) bad_rdy = 1'b1;
      n++;
      tick();
    end
    settle();
    chk("t5_msg1_blocked_in_wait", 128'(bad_rdy), 128'(0));
    chk("t5_wait_cycles", 128'(n), 128'(256));
    chk("t5_timeout_err", 128'(timeout_err), 128'(1));
    chk("t5_proto_err", 128'(proto_err), 128'(0));
    chk("t5_state_idle", 128'(cur_state), 128'(0));
    chk("t5_msg1_accepted", 128'(msg1_ready), 128'(1));
    sb.push_back(exp1(8'h06, 26'h400));
    tick(); set1(1'b0, 8'h0, 26'h0);
    tick();

    // 6: protocol error, then reset in WAIT_ACK with a held message
    pipe_ready = 1'b0; set1(1'b1, 8'h07, 26'h500); settle();
    chk("t6_load", 128'(msg1_ready), 128'(1));
    sb.push_back(exp1(8'h07, 26'h500));
    tick(); set1(1'b0, 8'h0, 26'h0); fwd_req = 1'b1; fwd_tag = 26'h222;
    tick(); settle();
    chk("t6_state_wait", 128'({cur_state, pipe_valid}), 128'({2'd1, 1'b1}));
    tick(); fwd_req = 1'b0; settle();
    chk("t6_proto_err", 128'(proto_err), 128'(1));
    chk("t6_fwd_ignored", 128'(cur_state), 128'(1));
    chk("t6_timeout_sticky", 128'(timeout_err), 128'(1));
    rst = 1'b1;
    tick(); settle();
    chk("t6_rst_pipe_valid", 128'(pipe_valid), 128'(0));
    chk("t6_rst_state", 128'(cur_state), 128'(0));
    chk("t6_rst_errs", 128'({timeout_err, proto_err}), 128'(0));
    chk("t6_rst_pipe_tag", 128'(pipe_tag), 128'(0));
    sb.delete();
    rst = 1'b0; pipe_ready = 1'b1;
    tick();
    set1(1'b1, 8'h08, 26'h600); settle();
    chk("t6_post_rst_grant", 128'(msg1_ready), 128'(1));
    sb.push_back(exp1(8'h08, 26'h600));
    tick(); set1(1'b0, 8'h0, 26'h0);
    tick(); tick();
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
